// File: rtl/pipe_control_unit.sv
// pipe_control_unit: pipelined opcode decoder. Decodes one opcode per cycle
// into a control word, carries it through ID/EX, EX/MEM and MEM/WB, and
// presents each field at the stage that consumes it. Handles stall, flush,
// the two-word LDM instruction, illegal opcodes and a retired counter.
//
// Handshake: a word on opcode is offered while instr_valid=1 and is consumed
// in exactly the cycles where accept=1 (accept = instr_valid & ~stall & ~flush).
// The front end must keep presenting the same word until it sees accept=1.
// imm_pending mirrors the FSM state (1 = IMM_WAIT) for observation.
module pipe_control_unit #(
  parameter int OPCODE_WIDTH   = 9,
  parameter int ALU_FUNC_WIDTH = 3,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      instr_valid,
  input  logic [OPCODE_WIDTH-1:0]   opcode,
  input  logic                      stall,
  input  logic                      flush,
  output logic                      accept,
  output logic                      imm_pending,
  output logic                      illegal,
  output logic                      ex_valid,
  output logic [ALU_FUNC_WIDTH-1:0] ex_alu_func,
  output logic                      ex_data_read,
  output logic                      ex_use_imm,
  output logic                      mem_valid,
  output logic                      mem_dmr,
  output logic                      mem_dmw,
  output logic                      wb_valid,
  output logic                      wb_data_write,
  output logic [CNT_WIDTH-1:0]      retired
);

  localparam logic [OPCODE_WIDTH-1:0] OP_NOP0  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_NOT   = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_NOP5  = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDM   = OPCODE_WIDTH'(6);

  typedef enum logic [0:0] {
    DECODE   = 1'b0,
    IMM_WAIT = 1'b1
  } state_t;

  // Full control word; a bubble is the all-zero value.
  typedef struct packed {
    logic                      valid;
    logic                      dmr;
    logic                      dmw;
    logic                      data_read;
    logic                      data_write;
    logic                      use_imm;
    logic [ALU_FUNC_WIDTH-1:0] alu_func;
  } ctrl_t;

  state_t state;
  state_t state_next;
  ctrl_t  dec;
  logic   dec_illegal;
  ctrl_t  id_ex;
  logic   ex_mem_valid, ex_mem_dmr, ex_mem_dmw, ex_mem_data_write;
  logic   mem_wb_valid, mem_wb_data_write;

  assign accept = instr_valid & ~stall & ~flush;

  // Decode the ID word and pick the next FSM state; anything not accepted is a bubble.
  always_comb begin
    dec         = '0;
    dec_illegal = 1'b0;
    state_next  = state;
    if (flush) begin
      state_next = DECODE;
    end else if (accept) begin
      if (state == IMM_WAIT) begin
        // Immediate word of LDM: never decoded as an opcode.
        dec.valid      = 1'b1;
        dec.data_write = 1'b1;
        dec.use_imm    = 1'b1;
        dec.alu_func   = ALU_FUNC_WIDTH'(3'b100);
        state_next     = DECODE;
      end else begin
        case (opcode)
          OP_LOAD: begin
            dec.valid      = 1'b1;
            dec.dmr        = 1'b1;
            dec.data_write = 1'b1;
            dec.alu_func   = ALU_FUNC_WIDTH'(3'b000);
          end
          OP_STORE: begin
            dec.valid     = 1'b1;
            dec.dmw       = 1'b1;
            dec.data_read = 1'b1;
            dec.alu_func  = ALU_FUNC_WIDTH'(3'b010);
          end
          OP_ADD: begin
            dec.valid      = 1'b1;
            dec.data_read  = 1'b1;
            dec.data_write = 1'b1;
            dec.alu_func   = ALU_FUNC_WIDTH'(3'b011);
          end
          OP_NOT: begin
            dec.valid      = 1'b1;
            dec.data_read  = 1'b1;
            dec.data_write = 1'b1;
            dec.alu_func   = ALU_FUNC_WIDTH'(3'b001);
          end
          OP_LDM:           state_next  = IMM_WAIT;
          OP_NOP0, OP_NOP5: dec_illegal = 1'b0;
          default:          dec_illegal = 1'b1;
        endcase
      end
    end
  end

  // FSM state with its registered outputs (imm_pending, illegal pulse).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= DECODE;
      imm_pending <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      state       <= state_next;
      imm_pending <= (state_next == IMM_WAIT);
      illegal     <= dec_illegal;
    end
  end

  // ID/EX takes the decoded word or a bubble every cycle; stall only withholds accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) id_ex <= '0;
    else     id_ex <= dec;
  end

  // EX/MEM and MEM/WB always advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_mem_valid      <= 1'b0;
      ex_mem_dmr        <= 1'b0;
      ex_mem_dmw        <= 1'b0;
      ex_mem_data_write <= 1'b0;
      mem_wb_valid      <= 1'b0;
      mem_wb_data_write <= 1'b0;
    end else begin
      ex_mem_valid      <= id_ex.valid;
      ex_mem_dmr        <= id_ex.dmr;
      ex_mem_dmw        <= id_ex.dmw;
      ex_mem_data_write <= id_ex.data_write;
      mem_wb_valid      <= ex_mem_valid;
      mem_wb_data_write <= ex_mem_data_write;
    end
  end

  // Count instructions leaving WB; wraps naturally at the counter width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               retired <= '0;
    else if (mem_wb_valid) retired <= retired + CNT_WIDTH'(1);
  end

  assign ex_valid      = id_ex.valid;
  assign ex_alu_func   = id_ex.alu_func;
  assign ex_data_read  = id_ex.data_read;
  assign ex_use_imm    = id_ex.use_imm;
  assign mem_valid     = ex_mem_valid;
  assign mem_dmr       = ex_mem_dmr;
  assign mem_dmw       = ex_mem_dmw;
  assign wb_valid      = mem_wb_valid;
  assign wb_data_write = mem_wb_data_write;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Bench for pipe_control_unit: reference decode table and pipeline model,
// expected ID/EX words queued at drive time and popped after each clock.
module tb_pipe_control_unit;

  localparam int OW = 9;
  localparam int AW = 3;
  localparam int CW = 4;
  localparam int W  = 9;  // {valid,dmr,dmw,data_read,data_write,use_imm,alu[2:0]}

  logic clk = 1'b0;
  logic rst, instr_valid, stall, flush;
  logic [OW-1:0] opcode;
  logic accept, imm_pending, illegal, ex_valid, ex_data_read, ex_use_imm;
  logic mem_valid, mem_dmr, mem_dmw, wb_valid, wb_data_write;
  logic [AW-1:0] ex_alu_func;
  logic [CW-1:0] retired;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  m_ex, m_mem, m_wb, exp_w;
  logic          m_imm, m_ill;
  logic [CW-1:0] m_ret;
  logic [10:0]   exp_p;
  logic [10:0]   pipe_obs;

  assign pipe_obs = {ex_valid, ex_data_read, ex_use_imm, ex_alu_func,
                     mem_valid, mem_dmr, mem_dmw, wb_valid, wb_data_write};

  pipe_control_unit #(.OPCODE_WIDTH(OW), .ALU_FUNC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode),
    .stall(stall), .flush(flush), .accept(accept), .imm_pending(imm_pending),
    .illegal(illegal), .ex_valid(ex_valid), .ex_alu_func(ex_alu_func),
    .ex_data_read(ex_data_read), .ex_use_imm(ex_use_imm), .mem_valid(mem_valid),
    .mem_dmr(mem_dmr), .mem_dmw(mem_dmw), .wb_valid(wb_valid),
    .wb_data_write(wb_data_write), .retired(retired)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_decode(input logic [OW-1:0] op);
    case (op)
      9'd1:    return 9'b1_1_0_0_1_0_000;
      9'd2:    return 9'b1_0_1_1_0_0_010;
      9'd3:    return 9'b1_0_0_1_1_0_011;
      9'd4:    return 9'b1_0_0_1_1_0_001;
      default: return '0;
    endcase
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_ex = '0; m_mem = '0; m_wb = '0;
    m_imm = 1'b0; m_ill = 1'b0; m_ret = '0;
  endtask

  task automatic set_in(input logic v, input logic [OW-1:0] op, input logic st, input logic fl);
    instr_valid = v; opcode = op; stall = st; flush = fl;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    set_in(1'b0, '0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Clock one cycle: predict from current inputs, queue the expected EX word, advance model.
  task automatic tick();
    logic acc, imm_n, ill_n;
    logic [W-1:0] w;
    acc   = instr_valid & ~stall & ~flush;
    w     = '0;
    imm_n = m_imm;
    ill_n = 1'b0;
    if (flush) imm_n = 1'b0;
    else if (acc) begin
      if (m_imm) begin
        w     = 9'b1_0_0_0_1_1_100;
        imm_n = 1'b0;
      end else if (opcode == 9'd6) begin
        imm_n = 1'b1;
      end else begin
        w     = ref_decode(opcode);
        ill_n = (opcode > 9'd6);
      end
    end
    exp_q.push_back(w);
    @(posedge clk); #1;
    m_ret = m_ret + {{(CW-1){1'b0}}, m_wb[8]};
    m_wb  = m_mem;
    m_mem = m_ex;
    m_ex  = w;
    m_imm = imm_n;
    m_ill = ill_n;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_in(1'b0, '0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({pipe_obs, imm_pending, illegal, retired} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b/%b/%b/%h want all zero", pipe_obs, imm_pending, illegal, retired);
    end
    set_in(1'b1, 9'd3, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (accept !== 1'b1) begin n_fail++; $display("FAIL reset_accept_on: got %b want 1", accept); end
    stall = 1'b1;
    #1;
    n_cmp++;
    if (accept !== 1'b0) begin n_fail++; $display("FAIL reset_accept_stall: got %b want 0", accept); end
    @(posedge clk); #1;
    rst = 1'b0;
    set_in(1'b0, '0, 1'b0, 1'b0);
    model_reset();
  endtask

  // Runs a stimulus list {valid,stall,flush,opcode} with per-cycle checks.
  task automatic test_run(input string name, input logic [11:0] s[$], input int want_ret);
    int ill_seen;
    ill_seen = 0;
    foreach (s[i]) begin
      set_in(s[i][11], s[i][8:0], s[i][10], s[i][9]);
      #1;
      n_cmp++;
      if (accept !== (s[i][11] & ~s[i][10] & ~s[i][9])) begin
        n_fail++;
        $display("FAIL %s accept cyc %0d: got %b want %b", name, i, accept, s[i][11] & ~s[i][10] & ~s[i][9]);
      end
      tick();
      exp_w = exp_q.pop_front();
      exp_p = {exp_w[8], exp_w[5], exp_w[3], exp_w[2:0], m_mem[8], m_mem[7], m_mem[6], m_wb[8], m_wb[4]};
      n_cmp++;
      if (pipe_obs !== exp_p) begin
        n_fail++;
        $display("FAIL %s pipe cyc %0d: got %b want %b", name, i, pipe_obs, exp_p);
      end
      n_cmp++;
      if ({imm_pending, illegal, retired} !== {m_imm, m_ill, m_ret}) begin
        n_fail++;
        $display("FAIL %s status cyc %0d: got imm=%b ill=%b ret=%0d want imm=%b ill=%b ret=%0d",
                 name, i, imm_pending, illegal, retired, m_imm, m_ill, m_ret);
      end
      if (illegal === 1'b1) ill_seen++;
    end
    n_cmp++;
    if (retired !== want_ret[CW-1:0]) begin
      n_fail++;
      $display("FAIL %s retired_final: got %0d want %0d", name, retired, want_ret[CW-1:0]);
    end
    if (name == "illegal") begin
      n_cmp++;
      if (ill_seen != 1) begin n_fail++; $display("FAIL illegal pulse_count: got %0d want 1", ill_seen); end
    end
  endtask

  task automatic test_decode_seq();
    logic [11:0] s[$];
    apply_reset();
    s = '{{3'b100, 9'd1}, {3'b100, 9'd2}, {3'b100, 9'd3}, {3'b100, 9'd4}, {3'b100, 9'd0}};
    repeat (4) s.push_back(12'h000);
    test_run("decode_seq", s, 4);
  endtask

  task automatic test_ldm();
    logic [11:0] s[$];
    apply_reset();
    s = '{{3'b100, 9'd6}, {3'b100, 9'h1A5}};
    repeat (4) s.push_back(12'h000);
    test_run("ldm", s, 1);
  endtask

  task automatic test_stall();
    logic [11:0] s[$];
    apply_reset();
    s = '{{3'b100, 9'd1}, {3'b110, 9'd3}, {3'b110, 9'd3}, {3'b100, 9'd3}};
    repeat (4) s.push_back(12'h000);
    test_run("stall", s, 2);
  endtask

  task automatic test_flush_in_imm_wait();
    logic [11:0] s[$];
    apply_reset();
    s = '{{3'b100, 9'd6}, {3'b111, 9'd3}, {3'b100, 9'd3}};
    repeat (4) s.push_back(12'h000);
    test_run("flush_imm", s, 1);
  endtask

  task automatic test_illegal();
    logic [11:0] s[$];
    apply_reset();
    s = '{{3'b100, 9'd3}, {3'b100, 9'h1FF}, {3'b100, 9'd3}};
    repeat (4) s.push_back(12'h000);
    test_run("illegal", s, 2);
  endtask

  task automatic test_counter_wrap();
    logic [11:0] s[$];
    apply_reset();
    repeat (17) s.push_back({3'b100, 9'd3});
    repeat (4) s.push_back(12'h000);
    test_run("wrap", s, 1);
  endtask

  task automatic test_async_reset();
    logic [11:0] s[$];
    apply_reset();
    s = '{{3'b100, 9'd3}, {3'b100, 9'd1}, {3'b100, 9'd6}};
    test_run("pre_reset", s, 0);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({pipe_obs, imm_pending, illegal, retired} !== '0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got %b/%b/%b/%h want all zero", pipe_obs, imm_pending, illegal, retired);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    s = '{{3'b100, 9'd3}};
    repeat (4) s.push_back(12'h000);
    test_run("post_reset", s, 1);
  endtask

  task automatic test_random();
    logic [11:0] s[$];
    logic [OW-1:0] op;
    int r;
    apply_reset();
    for (int i = 0; i < 60; i++) begin
      r  = $urandom_range(0, 8);
      op = (r == 8) ? 9'h1FF : r[OW-1:0];
      s.push_back({($urandom_range(0, 5) != 0), ($urandom_range(0, 4) == 0),
                   ($urandom_range(0, 7) == 0), op});
    end
    repeat (4) s.push_back(12'h000);
    foreach (s[i]) ;
    test_run("random", s, int'(count_expected(s)));
  endtask

  // Independent count of instructions expected to retire from a stimulus list.
  function automatic int count_expected(input logic [11:0] s[$]);
    int n;
    logic imm;
    n = 0; imm = 1'b0;
    foreach (s[i]) begin
      if (s[i][9]) imm = 1'b0;
      else if (s[i][11] & ~s[i][10]) begin
        if (imm) begin n++; imm = 1'b0; end
        else if (s[i][8:0] == 9'd6) imm = 1'b1;
        else if (s[i][8:0] >= 9'd1 && s[i][8:0] <= 9'd4) n++;
      end
    end
    return n % (1 << CW);
  endfunction

  initial begin
    test_reset();
    test_decode_seq();
    test_ldm();
    test_stall();
    test_flush_in_imm_wait();
    test_illegal();
    test_counter_wrap();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_control_unit.md
# pipe_control_unit

Parametrised, pipelined successor to the single-cycle opcode decoder. It decodes one opcode per cycle into a control word and carries that word through ID/EX, EX/MEM and MEM/WB stage registers, presenting each field at the stage that consumes it. It adds stall and flush handling, a two-word immediate-load instruction (LDM) run by a small state machine, illegal-opcode detection and a retired-instruction counter. It sits between the fetch/decode front end and the datapath of the five-stage processor.

## Interface

- OPCODE_WIDTH, 9, opcode field width; values above 6 are illegal.
- ALU_FUNC_WIDTH, 3, ALU function field width; minimum 3.
- CNT_WIDTH, 16, retired-instruction counter width.

- clk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  opcode (or immediate word) present this cycle.
- opcode  in  OPCODE_WIDTH  instruction opcode.
- stall  in  1  hold the instruction in ID and inject a bubble into EX.
- flush  in  1  discard the instruction in ID and the ID/EX contents.
- accept  out  1  combinational; the ID word is consumed this cycle.
- imm_pending  out  1  FSM in IMM_WAIT; the next valid word is an immediate.
- illegal  out  1  registered; pulses one cycle after an illegal opcode is accepted.
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_alu_func  out  ALU_FUNC_WIDTH  ALU function in EX.
- ex_data_read  out  1  register-file operand read needed.
- ex_use_imm  out  1  ALU operand B is the immediate.
- mem_valid, mem_dmr, mem_dmw  out  1 each  EX/MEM valid, data-memory read, data-memory write.
- wb_valid, wb_data_write  out  1 each  MEM/WB valid, register-file write.
- retired  out  CNT_WIDTH  count of instructions leaving WB.

## Operation

Decode table, giving {dmr, dmw, data_read, data_write, alu_func}:
- LOAD=1 -> {1,0,0,1,000}
- STORE=2 -> {0,1,1,0,010}
- ADD=3 -> {0,0,1,1,011}
- NOT=4 -> {0,0,1,1,001}
- NOP=0/5 -> all 0, with valid=0 downstream.
- LDM=6: the opcode word produces a bubble and the FSM moves to IMM_WAIT. The immediate word then produces {0,0,0,1,100} with use_imm=1.
- Any opcode from 7 up to 2^OPCODE_WIDTH−1 decodes as NOP, and `illegal` pulses.

State machine (states DECODE and IMM_WAIT):
- DECODE -> IMM_WAIT when LDM is accepted.
- IMM_WAIT -> DECODE when a word is accepted; that word is not decoded.
- In IMM_WAIT with instr_valid=0: stay and emit bubbles.

Acceptance and pipeline update:
- accept = instr_valid & ~stall & ~flush.
- ID/EX loads the decoded word when accept=1, otherwise a bubble.
- EX/MEM and MEM/WB always advance; stall never freezes them.
- flush forces ID/EX to a bubble and the FSM to DECODE. flush has priority over stall. EX/MEM and MEM/WB are unaffected.

Other behaviour:
- stall in IMM_WAIT holds the FSM in IMM_WAIT.
- retired increments when wb_valid=1 and wraps modulo 2^CNT_WIDTH.
- Bubble means every control field is 0 and valid=0; no control field is ever asserted with its stage valid=0.

## Timing

- Reset (asynchronous, takes effect immediately): FSM=DECODE; all stage registers are bubbles; every ex_/mem_/wb_ output is 0; illegal=0; retired=0; imm_pending=0. accept follows its inputs.
- An opcode accepted in cycle N appears on ex_* in N+1, mem_* in N+2 and wb_* in N+3. retired updates at the end of N+3.
- LDM accepted in N: imm_pending=1 from N+1. If the immediate is accepted in N+1, the LDM control word appears on ex_* in N+2 and imm_pending=0 from N+2. The LDM retires once.
- illegal is high in N+1 only, for an illegal opcode accepted in N.
- Stall held for k cycles: k bubbles enter EX. The held instruction is accepted in the first cycle with stall=0.
- Reset asserted mid-LDM returns the FSM to DECODE. The next word is decoded as an opcode.
- Throughput is one instruction per cycle with no stall; LDM costs two accept cycles.

## Test plan

- Reset, then LOAD, STORE, ADD, NOT, NOP back to back -> ex_* carries the table values in cycles 1–5, mem_/wb_ fields follow 1 and 2 cycles later, and retired=4 after the drain.
- LDM followed by immediate word 0x1A5 -> imm_pending high for one cycle, one bubble then ex_alu_func=100 with ex_use_imm=1, wb_data_write=1 three cycles later, retired=1.
- ADD with stall held 2 cycles -> accept=0 for 2 cycles, two bubbles in EX, ADD appears on ex_* in the cycle after stall drops, and the LOAD already in EX proceeds to MEM unaffected.
- LDM, then stall and flush asserted together in IMM_WAIT -> flush wins, the FSM returns to DECODE, and the next word 3 decodes as ADD, not as an immediate.
- Opcode 9'h1FF -> illegal pulses exactly once, ex_valid=0, and retired is unchanged.
- With CNT_WIDTH=4, retire 17 ADDs -> retired wraps to 1; asserting rst mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
